// File: rtl/frame_plotter_pkg.sv
// Shared screen geometry, coordinate widths and request-mode encodings
// for the frame plotter and its scan counter.
package frame_plotter_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_OBJ_W    = 4;
    localparam int DEF_OBJ_H    = 4;
    localparam logic [COLOUR_W-1:0] DEF_BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        MODE_DRAW  = 2'd0,
        MODE_ERASE = 2'd1,
        MODE_CLEAR = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Simultaneous requests resolve clear > erase > draw.
    function automatic mode_e pick_mode(input logic erase, input logic clear);
        if (clear) begin
            return MODE_CLEAR;
        end
        if (erase) begin
            return MODE_ERASE;
        end
        return MODE_DRAW;
    endfunction

endpackage

// File: rtl/frame_plotter_if.sv
// Request/completion and VGA write-port bundle between the state controller,
// the plotter (slave) and the VGA adapter.
interface frame_plotter_if;
    import frame_plotter_pkg::*;

    logic                req_draw;
    logic                req_erase;
    logic                req_clear;
    logic [X_W-1:0]      obj_x;
    logic [Y_W-1:0]      obj_y;
    logic [COLOUR_W-1:0] obj_colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport master (
        output req_draw, req_erase, req_clear, obj_x, obj_y, obj_colour,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  req_draw, req_erase, req_clear, obj_x, obj_y, obj_colour,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/frame_plotter_scan.sv
// 2-D raster counter: cx runs fastest, cy steps when cx wraps; last flags the final cell.
// cx/cy expose the value the counter takes on the coming edge so the caller can register it.
module pixel_scan_counter
    import frame_plotter_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           enable,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           x_end, y_end;

    assign x_end = (cx_q == width - X_W'(1));
    assign y_end = (cy_q == height - Y_W'(1));
    assign last  = x_end && y_end;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start) begin
            cx_d = '0;
            cy_d = '0;
        end else if (enable) begin
            if (x_end) begin
                cx_d = '0;
                cy_d = y_end ? '0 : cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    assign cx = cx_d;
    assign cy = cy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/frame_plotter.sv
// Scans a draw/erase box or the whole screen onto the VGA write port, one pixel per cycle.
// Pixel 0 appears the cycle after the accepting edge; requests arriving while busy are dropped.
module frame_plotter
    import frame_plotter_pkg::*;
#(
    parameter int                  SCREEN_W  = DEF_SCREEN_W,
    parameter int                  SCREEN_H  = DEF_SCREEN_H,
    parameter int                  OBJ_W     = DEF_OBJ_W,
    parameter int                  OBJ_H     = DEF_OBJ_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    frame_plotter_if.slave  ctl
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [X_W-1:0]      org_x_q, org_x_d, vga_x_q, vga_x_d;
    logic [Y_W-1:0]      org_y_q, org_y_d, vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d;
    logic                start, enable, emit, last, any_req;
    logic [X_W-1:0]      cx, scan_w;
    logic [Y_W-1:0]      cy, scan_h;
    logic [X_W:0]        pix_x;
    logic [Y_W:0]        pix_y;

    assign any_req = ctl.req_draw | ctl.req_erase | ctl.req_clear;
    assign scan_w  = (mode_q == MODE_CLEAR) ? X_W'(SCREEN_W) : X_W'(OBJ_W);
    assign scan_h  = (mode_q == MODE_CLEAR) ? Y_W'(SCREEN_H) : Y_W'(OBJ_H);

    pixel_scan_counter u_scan (
        .clk    (CLOCK_50),
        .rst    (reset),
        .start  (start),
        .enable (enable),
        .width  (scan_w),
        .height (scan_h),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        colour_d = colour_q;
        start    = 1'b0;
        enable   = 1'b0;
        emit     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    start    = 1'b1;
                    emit     = 1'b1;
                    state_d  = ST_SCAN;
                    mode_d   = pick_mode(ctl.req_erase, ctl.req_clear);
                    org_x_d  = (mode_d == MODE_CLEAR) ? '0 : ctl.obj_x;
                    org_y_d  = (mode_d == MODE_CLEAR) ? '0 : ctl.obj_y;
                    colour_d = (mode_d == MODE_DRAW) ? ctl.obj_colour : BG_COLOUR;
                end
            end
            ST_SCAN: begin
                enable = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    emit = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sum one bit wider than the coordinate so off-screen pixels clip instead of wrapping.
    always_comb begin
        pix_x        = {1'b0, org_x_d} + {1'b0, cx};
        pix_y        = {1'b0, org_y_d} + {1'b0, cy};
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (emit) begin
            vga_x_d      = pix_x[X_W-1:0];
            vga_y_d      = pix_y[Y_W-1:0];
            vga_colour_d = colour_d;
            vga_plot_d   = (pix_x < (X_W+1)'(SCREEN_W)) && (pix_y < (Y_W+1)'(SCREEN_H));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_DRAW;
            org_x_q      <= '0;
            org_y_q      <= '0;
            colour_q     <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            colour_q     <= colour_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign ctl.vga_x      = vga_x_q;
    assign ctl.vga_y      = vga_y_q;
    assign ctl.vga_colour = vga_colour_q;
    assign ctl.vga_plot   = vga_plot_q;
    assign ctl.busy       = (state_q != ST_IDLE);
    assign ctl.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_frame_plotter.sv
// Directed bench for frame_plotter: request vectors with hand-computed pixel
// counts and end points, plus reset-related sequences.
module tb_frame_plotter;
    import frame_plotter_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    frame_plotter_if ctl();

    frame_plotter dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .ctl      (ctl)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       d;
        logic       e;
        logic       c;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       mid;     // inject a draw request part-way through the scan
        int         w;
        int         h;
        int         ox;
        int         oy;
        logic [2:0] ecol;
        int         n_plot;
        int         fx;
        int         fy;
        int         lx;
        int         ly;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_reqs();
        ctl.req_draw  = 1'b0;
        ctl.req_erase = 1'b0;
        ctl.req_clear = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n, cnt, rerr, fx, fy, lx, ly, ex, ey;
        logic vis, done_ok, idle_ok;
        n   = v.w * v.h;
        cnt = 0; rerr = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        ctl.req_draw   = v.d;
        ctl.req_erase  = v.e;
        ctl.req_clear  = v.c;
        ctl.obj_x      = v.x;
        ctl.obj_y      = v.y;
        ctl.obj_colour = v.col;
        step();
        clear_reqs();
        ctl.obj_x      = 8'd77;
        ctl.obj_y      = 7'd33;
        ctl.obj_colour = 3'b111;
        for (int i = 0; i < n; i++) begin
            ex  = v.ox + (i % v.w);
            ey  = v.oy + (i / v.w);
            vis = (ex < 160) && (ey < 120);
            if (v.mid && i == 100) begin
                ctl.req_draw = 1'b1;
                ctl.obj_x    = 8'd5;
                ctl.obj_y    = 7'd5;
            end
            if (v.mid && i == 300) ctl.req_draw = 1'b0;
            if (ctl.vga_plot !== vis || ctl.busy !== 1'b1 || ctl.done !== 1'b0)
                rerr++;
            else if (vis && (ctl.vga_x !== ex[7:0] || ctl.vga_y !== ey[6:0] ||
                             ctl.vga_colour !== v.ecol))
                rerr++;
            if (ctl.vga_plot === 1'b1) begin
                cnt++;
                if (fx < 0) begin
                    fx = int'(ctl.vga_x);
                    fy = int'(ctl.vga_y);
                end
                lx = int'(ctl.vga_x);
                ly = int'(ctl.vga_y);
            end
            step();
        end
        done_ok = (ctl.done === 1'b1) && (ctl.busy === 1'b1) && (ctl.vga_plot === 1'b0);
        step();
        idle_ok = (ctl.done === 1'b0) && (ctl.busy === 1'b0) && (ctl.vga_plot === 1'b0);
        check($sformatf("v%0d plot_count", idx), cnt, v.n_plot);
        check($sformatf("v%0d first_pixel", idx), fx * 1000 + fy, v.fx * 1000 + v.fy);
        check($sformatf("v%0d last_pixel", idx), lx * 1000 + ly, v.lx * 1000 + v.ly);
        check($sformatf("v%0d raster_errors", idx), rerr, 0);
        check($sformatf("v%0d done_cycle", idx), {31'd0, done_ok}, 32'd1);
        check($sformatf("v%0d idle_after", idx), {31'd0, idle_ok}, 32'd1);
    endtask

    initial begin
        int done_seen;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd10,  7'd20,  3'd4, 1'b0, 4,   4,   10,  20,  3'd4, 16,    10,  20,  13,  23};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd10,  7'd20,  3'd5, 1'b0, 4,   4,   10,  20,  3'd0, 16,    10,  20,  13,  23};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd158, 7'd118, 3'd2, 1'b0, 4,   4,   158, 118, 3'd2, 4,     158, 118, 159, 119};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'd50,  7'd30,  3'd6, 1'b1, 160, 120, 0,   0,   3'd0, 19200, 0,   0,   159, 119};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd40,  7'd40,  3'd7, 1'b0, 160, 120, 0,   0,   3'd0, 19200, 0,   0,   159, 119};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd157, 7'd0,   3'd3, 1'b0, 4,   4,   157, 0,   3'd3, 12,    157, 0,   159, 3};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'd0,   7'd126, 3'd1, 1'b0, 4,   4,   0,   126, 3'd1, 0,     -1,  -1,  -1,  -1};

        // Reset held with a draw request pending: nothing may start.
        reset          = 1'b1;
        ctl.req_draw   = 1'b1;
        ctl.req_erase  = 1'b0;
        ctl.req_clear  = 1'b0;
        ctl.obj_x      = 8'd10;
        ctl.obj_y      = 7'd20;
        ctl.obj_colour = 3'b100;
        repeat (3) step();
        check("reset_outputs",
              {12'd0, ctl.vga_x, ctl.vga_y, ctl.vga_colour, ctl.vga_plot, ctl.busy, ctl.done},
              32'd0);
        reset = 1'b0;
        step();
        check("accept_after_reset", {15'd0, ctl.busy, ctl.vga_plot, ctl.vga_x, ctl.vga_y},
              {15'd0, 1'b1, 1'b1, 8'd10, 7'd20});
        clear_reqs();
        repeat (17) step();
        check("idle_after_first_draw", {30'd0, ctl.busy, ctl.done}, 32'd0);

        // Reset while pixel 5 of a draw is on the port.
        ctl.req_draw   = 1'b1;
        ctl.obj_colour = 3'b011;
        step();
        clear_reqs();
        repeat (5) step();
        check("pixel5_coords", {16'd0, ctl.vga_plot, ctl.vga_x, ctl.vga_y},
              {16'd0, 1'b1, 8'd11, 7'd21});
        reset = 1'b1;
        step();
        check("mid_scan_reset", {29'd0, ctl.vga_plot, ctl.busy, ctl.done}, 32'd0);
        reset     = 1'b0;
        done_seen = 0;
        repeat (20) begin
            step();
            if (ctl.done === 1'b1 || ctl.busy === 1'b1) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);

        for (int k = 0; k < 7; k++) begin
            run_vec(tbl[k], k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
